// File: rtl/mc_cu_pkg.sv
// mc_cu_pkg
// Shared definitions for the multi-cycle control unit: the controller state
// encoding, RV32I major opcodes, ALU operation codes and register write-back
// select codes. Imported by mc_cu_decoder and mc_control_unit.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        TRAP,
        ERROR
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_IL    = 7'b0000011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;

    localparam logic [1:0] WSEL_ALU  = 2'b00;
    localparam logic [1:0] WSEL_LOAD = 2'b01;
    localparam logic [1:0] WSEL_LUI  = 2'b10;
    localparam logic [1:0] WSEL_PC   = 2'b11;

endpackage

// File: rtl/mc_cu_decoder.sv
// mc_cu_decoder
// Purely combinational instruction decode for the multi-cycle control unit.
// Ports:
//   instr_code    in  32  current IR contents
//   alu_controls  out  4  ALU operation code
//   alu_src_sel   out  1  0 = rs2, 1 = immediate
//   reg_wdata_sel out  2  register write-back source
//   is_load, is_store, branch, jal, jalr  out 1 each  instruction class
//   legal         out  1  opcode is one of the supported RV32I classes
module mc_cu_decoder
    import mc_cu_pkg::*;
(
    input  logic [31:0] instr_code,
    output logic [3:0]  alu_controls,
    output logic        alu_src_sel,
    output logic [1:0]  reg_wdata_sel,
    output logic        is_load,
    output logic        is_store,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_bits;

    assign opcode      = instr_code[6:0];
    assign funct3      = instr_code[14:12];
    assign funct7_b5   = instr_code[30];
    // Register indices and immediates are consumed by the datapath, not here.
    assign unused_bits = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

    // Unknown opcodes fall through to the all-zero defaults so that
    // alu_controls is always a defined ADD rather than X.
    always_comb begin
        alu_controls  = ALU_ADD;
        alu_src_sel   = 1'b0;
        reg_wdata_sel = WSEL_ALU;
        is_load       = 1'b0;
        is_store      = 1'b0;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        legal         = 1'b1;
        case (opcode)
            OP_R: begin
                alu_controls = {funct7_b5, funct3};
            end
            OP_I: begin
                // Only the shift-right pair uses bit 30 to pick SRLI/SRAI;
                // for the rest it is immediate data.
                alu_controls = (funct3 == 3'b101) ? {funct7_b5, funct3} : {1'b0, funct3};
                alu_src_sel  = 1'b1;
            end
            OP_IL: begin
                alu_src_sel   = 1'b1;
                reg_wdata_sel = WSEL_LOAD;
                is_load       = 1'b1;
            end
            OP_S: begin
                alu_src_sel = 1'b1;
                is_store    = 1'b1;
            end
            OP_B: begin
                alu_controls = {1'b0, funct3};
                branch       = 1'b1;
            end
            OP_LUI: begin
                alu_src_sel   = 1'b1;
                reg_wdata_sel = WSEL_LUI;
            end
            OP_AUIPC: begin
                alu_src_sel   = 1'b1;
                reg_wdata_sel = WSEL_PC;
            end
            OP_JAL: begin
                alu_src_sel   = 1'b1;
                reg_wdata_sel = WSEL_PC;
                jal           = 1'b1;
            end
            OP_JALR: begin
                alu_src_sel   = 1'b1;
                reg_wdata_sel = WSEL_PC;
                jalr          = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit
// Multi-cycle RV32I controller: sequences FETCH/DECODE/EXECUTE/MEM/WB for one
// instruction at a time against variable-latency instruction/data memories,
// with a wait-timeout watchdog and a retired-instruction counter.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes trap instead of
// retiring as NOPs).
// Ports:
//   clk, reset (async, active-high)
//   instr_code in 32; i_ready, d_ready in 1
//   i_req, ir_en, pc_en, d_req, d_we, reg_wr_en  out strobes
//   alu_controls out 4; alu_src_sel out 1; reg_wdata_sel out 2
//   is_load, is_store, branch, jal, jalr out class flags
//   illegal_instr, bus_err out sticky flags; instret out CNT_W
module mc_control_unit
    import mc_cu_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_code,
    input  logic             i_ready,
    input  logic             d_ready,
    output logic             i_req,
    output logic             ir_en,
    output logic             pc_en,
    output logic             d_req,
    output logic             d_we,
    output logic             reg_wr_en,
    output logic [3:0]       alu_controls,
    output logic             alu_src_sel,
    output logic [1:0]       reg_wdata_sel,
    output logic             is_load,
    output logic             is_store,
    output logic             branch,
    output logic             jal,
    output logic             jalr,
    output logic             illegal_instr,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    localparam int             WD_W      = $clog2(MAX_WAIT + 1);
    localparam logic [WD_W-1:0] WAIT_LAST = WD_W'(MAX_WAIT - 1);

    state_t          state;
    state_t          next_state;
    logic [WD_W-1:0] wait_cnt;
    logic            legal;

    mc_cu_decoder u_decoder (
        .instr_code    (instr_code),
        .alu_controls  (alu_controls),
        .alu_src_sel   (alu_src_sel),
        .reg_wdata_sel (reg_wdata_sel),
        .is_load       (is_load),
        .is_store      (is_store),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .legal         (legal)
    );

    // Next-state and strobe generation. A ready arriving in the same cycle
    // the watchdog would expire is checked first, so it wins.
    always_comb begin
        next_state = state;
        i_req      = 1'b0;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        reg_wr_en  = 1'b0;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                i_req = 1'b1;
                if (i_ready) begin
                    ir_en      = 1'b1;
                    next_state = DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = ERROR;
                end
            end
            DECODE: next_state = EXECUTE;
            EXECUTE: begin
                if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
                    next_state = TRAP;
`else
                    pc_en      = 1'b1;
                    next_state = FETCH;
`endif
                end else if (is_load || is_store) begin
                    next_state = MEM;
                end else if (branch) begin
                    pc_en      = 1'b1;
                    next_state = FETCH;
                end else begin
                    next_state = WB;
                end
            end
            MEM: begin
                d_req = 1'b1;
                d_we  = is_store;
                if (d_ready) begin
                    if (is_store) begin
                        pc_en      = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = ERROR;
                end
            end
            WB: begin
                reg_wr_en  = 1'b1;
                pc_en      = 1'b1;
                next_state = FETCH;
            end
            TRAP:    next_state = TRAP;
            ERROR:   next_state = ERROR;
            default: next_state = IDLE;
        endcase
    end

    // State register, watchdog and counters. The watchdog restarts on every
    // state change, so it is zero on entry to FETCH and MEM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            instret  <= '0;
            bus_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if ((state == FETCH && !i_ready) || (state == MEM && !d_ready)) begin
                wait_cnt <= wait_cnt + WD_W'(1);
            end
            if (pc_en) begin
                instret <= instret + CNT_W'(1);
            end
            if (next_state == ERROR) begin
                bus_err <= 1'b1;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky record that an illegal opcode reached EXECUTE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_instr <= 1'b0;
        end else if (next_state == TRAP) begin
            illegal_instr <= 1'b1;
        end
    end
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit
// Scoreboard bench for mc_control_unit: the driver pushes the expected
// retirement of each instruction, a monitor pops and compares on pc_en.
module tb_mc_control_unit;

    localparam int MAX_WAIT = 255;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      instr_code = 32'h0;
    logic             i_ready = 1'b0;
    logic             d_ready = 1'b0;
    logic             i_req, ir_en, pc_en, d_req, d_we, reg_wr_en;
    logic [3:0]       alu_controls;
    logic             alu_src_sel;
    logic [1:0]       reg_wdata_sel;
    logic             is_load, is_store, branch, jal, jalr;
    logic             illegal_instr, bus_err;
    logic [CNT_W-1:0] instret;

    typedef struct {
        logic [3:0] alu;
        logic       src;
        logic [1:0] sel;
        logic [4:0] cls;
        logic       wr;
        logic       dwe;
        logic       ill;
        int         lat;
        int         ireq;
        int         dreq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   retired = 0;
    int   model_count = 0;

    mc_control_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_code    (instr_code),
        .i_ready       (i_ready),
        .d_ready       (d_ready),
        .i_req         (i_req),
        .ir_en         (ir_en),
        .pc_en         (pc_en),
        .d_req         (d_req),
        .d_we          (d_we),
        .reg_wr_en     (reg_wr_en),
        .alu_controls  (alu_controls),
        .alu_src_sel   (alu_src_sel),
        .reg_wdata_sel (reg_wdata_sel),
        .is_load       (is_load),
        .is_store      (is_store),
        .branch        (branch),
        .jal           (jal),
        .jalr          (jalr),
        .illegal_instr (illegal_instr),
        .bus_err       (bus_err),
        .instret       (instret)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Reference: what an instruction should look like at retirement, built
    // from the opcode table and the cycle budget F+D+E (+MEM) (+WB) plus waits.
    function automatic exp_t model(input logic [31:0] ins, input int iw, input int dw);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        bit         mem;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[30];
        e.alu = 4'd0; e.src = 1'b1; e.sel = 2'd0; e.cls = 5'd0;
        e.wr = 1'b1; e.dwe = 1'b0; e.ill = 1'b0;
        mem = 1'b0;
        case (op)
            7'h33: begin e.alu = {f7, f3}; e.src = 1'b0; end
            7'h13: e.alu = (f3 == 3'd5) ? {f7, f3} : {1'b0, f3};
            7'h03: begin e.sel = 2'd1; e.cls = 5'b10000; mem = 1'b1; end
            7'h23: begin e.wr = 1'b0; e.dwe = 1'b1; e.cls = 5'b01000; mem = 1'b1; end
            7'h63: begin e.alu = {1'b0, f3}; e.src = 1'b0; e.wr = 1'b0; e.cls = 5'b00100; end
            7'h37: e.sel = 2'd2;
            7'h17: e.sel = 2'd3;
            7'h6F: begin e.sel = 2'd3; e.cls = 5'b00010; end
            7'h67: begin e.sel = 2'd3; e.cls = 5'b00001; end
            default: begin e.src = 1'b0; e.wr = 1'b0; e.ill = 1'b1; end
        endcase
        e.ireq = iw + 1;
        e.dreq = mem ? dw + 1 : 0;
        e.lat  = 3 + e.ireq - 1 + e.dreq + (e.wr ? 1 : 0);
        return e;
    endfunction

    // Monitor: samples 2 units after each falling edge, accumulates per-
    // instruction activity and compares against the scoreboard on pc_en.
    int cycle = 0;
    int fetch_start = 0;
    bit in_flight = 0;
    int ireq_cnt = 0;
    int dreq_cnt = 0;
    int ir_cnt = 0;
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (reset) begin
            in_flight = 0; ireq_cnt = 0; dreq_cnt = 0; ir_cnt = 0;
            model_count = 0;
            sb.delete();
        end else begin
            cycle++;
            if (i_req && !in_flight) begin
                in_flight   = 1;
                fetch_start = cycle;
            end
            if (i_req) ireq_cnt++;
            if (d_req) dreq_cnt++;
            if (ir_en) ir_cnt++;
            checkOutput("dwe_without_dreq", {31'd0, d_we & ~d_req}, 32'd0);
            if (pc_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_retire: got pc_en=1, expected no retirement");
                end else begin
                    e = sb.pop_front();
                    checkOutput("alu_controls", alu_controls, e.alu);
                    checkOutput("alu_src_sel", alu_src_sel, e.src);
                    checkOutput("reg_wdata_sel", reg_wdata_sel, e.sel);
                    checkOutput("class", {is_load, is_store, branch, jal, jalr}, e.cls);
                    checkOutput("reg_wr_en", reg_wr_en, e.wr);
                    checkOutput("d_we_at_retire", d_we, e.dwe);
                    checkOutput("latency", cycle - fetch_start + 1, e.lat);
                    checkOutput("i_req_cycles", ireq_cnt, e.ireq);
                    checkOutput("d_req_cycles", dreq_cnt, e.dreq);
                    checkOutput("ir_en_pulses", ir_cnt, 1);
                    checkOutput("instret", instret, model_count);
                end
                model_count++;
                retired++;
                in_flight = 0; ireq_cnt = 0; dreq_cnt = 0; ir_cnt = 0;
            end else begin
                checkOutput("wr_without_pc_en", {31'd0, reg_wr_en}, 32'd0);
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        reset   = 1'b1;
        i_ready = 1'b0;
        d_ready = 1'b0;
        #1;
        checkOutput("rst_instret", instret, 0);
        checkOutput("rst_bus_err", bus_err, 0);
        checkOutput("rst_illegal", illegal_instr, 0);
        checkOutput("rst_strobes", {i_req, ir_en, pc_en, d_req, d_we, reg_wr_en}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitFor(input string name, input bit want_d);
        int n = 0;
        while (!(want_d ? d_req : i_req) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(want_d ? d_req : i_req)) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: request not seen within 20 cycles", name);
        end
    endtask

    // Drives one instruction through fetch (iw wait cycles) and, for memory
    // ops, the data access (dw wait cycles); returns in the next FETCH cycle.
    task automatic applyStimulus(input logic [31:0] instr, input int iw, input int dw);
        exp_t e;
        int   n;
        int   r0;
        bit   trap;
        e    = model(instr, iw, dw);
        trap = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        trap = e.ill;
`endif
        instr_code = instr;
        r0 = retired;
        if (!trap) sb.push_back(e);
        waitFor("fetch_req", 1'b0);
        repeat (iw) @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        if (e.dreq != 0) begin
            waitFor("data_req", 1'b1);
            repeat (dw) @(negedge clk);
            d_ready = 1'b1;
            @(negedge clk);
            d_ready = 1'b0;
        end
        if (trap) begin
            repeat (4) @(negedge clk);
            checkOutput("trap_illegal_flag", illegal_instr, 1);
            checkOutput("trap_strobes", {i_req, ir_en, pc_en, d_req, d_we, reg_wr_en}, 0);
            doReset();
        end else begin
            n = 0;
            while (retired == r0 && n < MAX_WAIT + 20) begin
                @(negedge clk);
                n++;
            end
            if (retired == r0) begin
                checks++;
                errors++;
                $display("[TB] FAIL retire_timeout: instr %h not retired", instr);
            end
        end
    endtask

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};

    initial begin
        logic [31:0] r;
        doReset();

        // Directed instructions from the test plan.
        applyStimulus(32'h002081B3, 0, 0);
        applyStimulus(32'h0000A183, 0, 3);
        applyStimulus(32'h0020A023, 0, 0);
        applyStimulus(32'h00208063, 0, 0);
        applyStimulus(32'h4020D093, 0, 0);
        applyStimulus(32'hFFFFFFFF, 0, 0);

        // Randomized mix with random memory latencies.
        for (int i = 0; i < 40; i++) begin
            r = $urandom();
            applyStimulus({r[31:7], ops[$urandom_range(0, 9)]}, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Ready arriving on exactly the last allowed fetch cycle.
        applyStimulus(32'h002081B3, MAX_WAIT - 1, 0);
        checkOutput("bus_err_at_limit", bus_err, 0);

        // Watchdog expiry on fetch.
        instr_code = 32'h002081B3;
        waitFor("wd_fetch_req", 1'b0);
        repeat (MAX_WAIT - 1) @(negedge clk);
        checkOutput("wd_pre_bus_err", bus_err, 0);
        checkOutput("wd_pre_i_req", i_req, 1);
        @(negedge clk);
        checkOutput("wd_bus_err", bus_err, 1);
        i_ready = 1'b1;
        #1;
        checkOutput("wd_err_strobes", {i_req, ir_en, pc_en, d_req, d_we, reg_wr_en}, 0);
        repeat (3) @(negedge clk);
        checkOutput("wd_err_held", {bus_err, i_req, ir_en, pc_en}, 4'b1000);
        i_ready = 1'b0;
        doReset();

        // Watchdog expiry on a data access.
        instr_code = 32'h0000A183;
        waitFor("wd_d_fetch", 1'b0);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        waitFor("wd_d_req", 1'b1);
        repeat (MAX_WAIT) @(negedge clk);
        checkOutput("wd_d_bus_err", bus_err, 1);
        checkOutput("wd_d_strobes", {i_req, d_req, d_we, pc_en, reg_wr_en}, 0);
        doReset();

        // Retire two, then reset in the middle of a third.
        applyStimulus(32'h002081B3, 1, 0);
        applyStimulus(32'h00000037, 0, 0);
        checkOutput("instret_before_abort", instret, 2);
        instr_code = 32'h002081B3;
        waitFor("abort_fetch", 1'b0);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_instret", instret, 0);
        checkOutput("abort_strobes", {pc_en, reg_wr_en, i_req}, 0);
        repeat (3) @(negedge clk);
        checkOutput("abort_no_pulse", {pc_en, reg_wr_en}, 0);
        reset = 1'b0;
        applyStimulus(32'h0020A023, 2, 1);

        repeat (2) @(negedge clk);
        checkOutput("pending_expected", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle successor to the single-cycle RV32I control path: a state-machine controller that sequences FETCH/DECODE/EXECUTE/MEM/WB for one instruction at a time. It drives PC/IR enables, memory request handshakes and datapath selects, and tolerates variable-latency instruction and data memories. A wait-timeout watchdog and a retired-instruction counter are included. It sits between the IR/PC registers, the register file, the ALU and the SLU/RAM interface.

## Interface
- MAX_WAIT, 255: maximum cycles a memory request may stay unanswered before ERROR.
- CNT_W, 32: width of the retired-instruction counter.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- instr_code  input  32  current IR contents; must be stable from DECODE through retirement.
- i_ready  input  1  instruction memory has data this cycle.
- d_ready  input  1  data memory has completed the access this cycle.
- i_req  output  1  instruction fetch request.
- ir_en  output  1  load IR, one-cycle pulse.
- pc_en  output  1  update PC (next-PC mux chooses target), one-cycle pulse at retirement.
- d_req  output  1  data memory request.
- d_we  output  1  data write (store) qualifier for d_req.
- reg_wr_en  output  1  register-file write, one-cycle pulse in WB.
- alu_controls  output  4  ALU operation code.
- alu_src_sel  output  1  0 = rs2, 1 = immediate.
- reg_wdata_sel  output  2  00 ALU, 01 load data, 10 LUI immediate, 11 PC+4/AUIPC.
- is_load, is_store, branch, jal, jalr  output  1 each  decoded instruction class.
- illegal_instr  output  1  sticky illegal-opcode flag.
- bus_err  output  1  sticky memory-timeout flag.
- instret  output  CNT_W  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP, ERROR.
- IDLE → FETCH unconditionally (one cycle after reset release).
- FETCH: i_req=1; on i_ready: ir_en=1, → DECODE.
- DECODE: one cycle, → EXECUTE.
- EXECUTE: R/I-ALU/LUI/AUIPC/JAL/JALR → WB; load/store → MEM; branch → FETCH with pc_en=1; illegal opcode → see Configuration.
- MEM: d_req=1, d_we=is_store; on d_ready: store → FETCH with pc_en=1; load → WB.
- WB: reg_wr_en=1, pc_en=1, → FETCH.
- ALU code: R-type {funct7[5],funct3}; I-ALU {funct7[5],funct3} when funct3=101, else {0,funct3}; branch {0,funct3}; load/store/AUIPC/JAL/JALR ADD (0000); all other opcodes 0000 (never X).
- Class outputs and selects are combinational from instr_code; strobes (i_req, ir_en, pc_en, d_req, d_we, reg_wr_en) are valid only in their states, 0 elsewhere.
- instret increments by 1 on every pc_en; wraps at 2^CNT_W−1 → 0.
- Watchdog: counter cleared on entry to FETCH/MEM, increments each cycle ready is low; reaching MAX_WAIT → ERROR, bus_err=1. Ready in the same cycle as reaching MAX_WAIT wins (normal transition).
- ERROR: all strobes 0, held until reset.

## Timing
- Reset (async): state IDLE, instret 0, illegal_instr 0, bus_err 0, watchdog 0; all strobes 0.
- Zero-wait memories: ALU/jump 4 cycles, load 5, store 4, branch 3 (FETCH→retire).
- Each wait cycle of i_ready/d_ready adds one cycle; i_req/d_req held high and constant until ready.
- reset asserted mid-instruction: state abandons immediately; no pc_en/reg_wr_en pulse is emitted.

## Configuration
- ILLEGAL_TRAP_EN defined: illegal opcode in EXECUTE → TRAP; illegal_instr=1 sticky, all strobes 0, held until reset; no pc_en, no instret increment.
- Not defined: illegal opcode treated as NOP: EXECUTE → FETCH with pc_en=1, instret increments, no register write; TRAP unreachable, illegal_instr tied 0.

## Structure
- Shared package mc_cu_pkg: state enum, opcode constants (R, S, IL, I, B, LUI, AUIPC, JAL, JALR), ALU op codes, reg_wdata_sel codes.
- Sub-module mc_cu_decoder: combinational decode of instr_code → alu_controls, selects, class flags, legal flag; FSM, watchdog and instret in top.

## Test plan
- Reset release, i_ready=1, instr 0x002081B3 (add x3,x1,x2) → i_req cycle 1, reg_wr_en pulse in cycle 4 with alu_controls 0000, sel 00, instret=1.
- lw 0x0000A183 with d_ready delayed 3 cycles → d_req/d_we=1/0 held 4 cycles, reg_wr_en with sel 01, total 8 cycles.
- sw 0x0020A023, d_ready=1 → d_we=1 in MEM, pc_en same cycle, no reg_wr_en.
- beq 0x00208063 → alu_controls 0000, branch=1, pc_en in cycle 3, no write; srai 0x4020D093 → alu_controls 1101.
- i_ready held low MAX_WAIT cycles → bus_err=1, ERROR, strobes 0; i_ready on cycle MAX_WAIT exactly → normal DECODE.
- instr 0xFFFFFFFF: with ILLEGAL_TRAP_EN → illegal_instr=1, no pc_en; without → pc_en pulse, instret+1, no write.
